// File: rtl/me_search_sequencer.sv
// Motion-estimation search sequencer.
// Enables the SAD control unit for a fixed number of cycles, then waits a
// bounded time for outstanding SAD results. Tracks the minimum SAD and the
// position of that candidate, and pulses done when the search ends.
module me_search_sequencer #(
    parameter  int SAD_WIDTH    = 16,
    parameter  int CAND_COUNT   = 256,
    parameter  int RUN_CYCLES   = 4096,
    parameter  int DRAIN_CYCLES = 32,
    localparam int CNT_W        = $clog2(CAND_COUNT) + 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_start,
    input  logic                 in_sad_valid,
    input  logic [SAD_WIDTH-1:0] in_sad,
    output logic                 out_cu_ena,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_err,
    output logic [SAD_WIDTH-1:0] out_best_sad,
    output logic [3:0]           out_best_mv_x,
    output logic [3:0]           out_best_mv_y,
    output logic [CNT_W-1:0]     out_cand_cnt
);

    localparam int RUN_W   = $clog2(RUN_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0]   CAND_MAX   = CNT_W'(CAND_COUNT);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_timeout;

    logic [RUN_W-1:0]     r_run_cnt;
    logic [DRAIN_W-1:0]   r_drain_cnt;

    logic [CNT_W-1:0]     r_cand_cnt;
    logic [SAD_WIDTH-1:0] r_best_sad;
    logic [3:0]           r_best_mv_x;
    logic [3:0]           r_best_mv_y;
    logic                 r_err;
    logic                 r_cu_ena;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_active;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_full_next;
    logic [7:0]           w_idx;

    // A SAD is taken only while a search is live and the grid is not yet full.
    assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_accept    = in_sad_valid && w_active && (r_cand_cnt < CAND_MAX);
    assign w_cnt_inc   = r_cand_cnt + CNT_W'(1);
    // Grid is complete after this edge (counts a SAD accepted on this same edge).
    assign w_full_next = (r_cand_cnt == CAND_MAX) || (w_accept && (w_cnt_inc == CAND_MAX));
    // Candidate index is the count before increment; low nibble is x, next is y.
    assign w_idx       = 8'(r_cand_cnt);

    // State register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (in_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; completion beats timeout when both land on one edge.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_start) w_next = S_RUN;
            end
            S_RUN: begin
                if (r_run_cnt == RUN_LAST) w_next = w_full_next ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_full_next) begin
                    w_next = S_DONE;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_next    = S_DONE;
                    w_timeout = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Cycle counters for the RUN window and the DRAIN timeout; zero outside.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_run_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_run_cnt   <= (r_state == S_RUN)   ? r_run_cnt + RUN_W'(1)     : '0;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
        end
    end

    // Result tracking: cleared on an accepted start, updated per accepted SAD.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_cand_cnt  <= '0;
            r_best_sad  <= '0;
            r_best_mv_x <= '0;
            r_best_mv_y <= '0;
            r_err       <= 1'b0;
        end else if ((r_state == S_IDLE) && in_start) begin
            r_cand_cnt  <= '0;
            r_best_sad  <= '1;
            r_best_mv_x <= '0;
            r_best_mv_y <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cand_cnt <= w_cnt_inc;
                // Strict compare keeps the lower index on ties.
                if ((r_cand_cnt == '0) || (in_sad < r_best_sad)) begin
                    r_best_sad  <= in_sad;
                    r_best_mv_x <= w_idx[3:0];
                    r_best_mv_y <= w_idx[7:4];
                end
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_cu_ena <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cu_ena <= (w_next == S_RUN);
            r_busy   <= (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done   <= (w_next == S_DONE);
        end
    end

    assign out_cu_ena    = r_cu_ena;
    assign out_busy      = r_busy;
    assign out_done      = r_done;
    assign out_err       = r_err;
    assign out_best_sad  = r_best_sad;
    assign out_best_mv_x = r_best_mv_x;
    assign out_best_mv_y = r_best_mv_y;
    assign out_cand_cnt  = r_cand_cnt;

endmodule

// File: tb/tb_me_search_sequencer.sv
// Self-checking bench for me_search_sequencer with a behavioural model:
// the expected best is the first minimum over the first 256 SADs delivered,
// and completion timing follows from the RUN length and DRAIN bound.
module tb_me_search_sequencer;

    localparam int SW    = 16;
    localparam int NCAND = 256;
    localparam int RUNC  = 4096;
    localparam int DRNC  = 32;
    localparam int LAST  = 4140;

    logic          in_clk;
    logic          in_rst;
    logic          in_start;
    logic          in_sad_valid;
    logic [SW-1:0] in_sad;
    logic          out_cu_ena;
    logic          out_busy;
    logic          out_done;
    logic          out_err;
    logic [SW-1:0] out_best_sad;
    logic [3:0]    out_best_mv_x;
    logic [3:0]    out_best_mv_y;
    logic [8:0]    out_cand_cnt;

    me_search_sequencer dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_start     (in_start),
        .in_sad_valid (in_sad_valid),
        .in_sad       (in_sad),
        .out_cu_ena   (out_cu_ena),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_err      (out_err),
        .out_best_sad (out_best_sad),
        .out_best_mv_x(out_best_mv_x),
        .out_best_mv_y(out_best_mv_y),
        .out_cand_cnt (out_cand_cnt)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] sads [0:259];

    // Model expectations
    int exp_cnt, exp_idx, exp_done_cyc;
    int unsigned exp_best;
    bit exp_err;
    int exp_cnt_pulse;

    // Observations from the last search
    int obs_cu_cycles, obs_cu_first, obs_cu_last;
    int obs_done_cnt, obs_done_cyc, obs_cnt_pulse;
    bit obs_busy_mid, obs_busy_end, obs_cu_at_pulse, obs_idle_stable;
    int obs_cnt, obs_mx, obs_my;
    int unsigned obs_best;
    bit obs_err;

    // Behavioural model: first minimum over the first NCAND delivered SADs.
    function automatic void model(input int n, input int late);
        exp_cnt  = (n > NCAND) ? NCAND : n;
        exp_best = 32'hFFFF;
        exp_idx  = 0;
        for (int i = 0; i < exp_cnt; i++) begin
            if (i == 0 || int'(sads[i]) < int'(exp_best)) begin
                exp_best = sads[i];
                exp_idx  = i;
            end
        end
        exp_err = (n < NCAND);
        if (exp_err)        exp_done_cyc = RUNC + DRNC;
        else if (late >= 0) exp_done_cyc = RUNC + 1 + late;
        else                exp_done_cyc = RUNC;
    endfunction

    // Drive one search and record what the DUT did. Cycle 0 is the first
    // cycle after the edge that samples in_start.
    task automatic do_search(input int n, input bit gaps, input bit pulse, input int late);
        int sent;
        int n_early;
        bit send;
        logic [SW-1:0] snap_best;
        logic [8:0]    snap_cnt;
        logic [3:0]    snap_mx, snap_my;
        logic          snap_err;
        model(n, late);
        n_early = (late >= 0) ? n - 1 : n;
        sent = 0;
        obs_cu_cycles = 0; obs_cu_first = -1; obs_cu_last = -1;
        obs_done_cnt = 0;  obs_done_cyc = -1; obs_cnt_pulse = -1;
        obs_busy_mid = 0;  obs_cu_at_pulse = 0; exp_cnt_pulse = 0;
        in_sad_valid = 1'b0;
        @(posedge in_clk); #1;
        in_start = 1'b1;
        @(posedge in_clk); #1;
        in_start = 1'b0;
        for (int cyc = 0; cyc <= LAST; cyc++) begin
            if (out_cu_ena) begin
                obs_cu_cycles++;
                if (obs_cu_first < 0) obs_cu_first = cyc;
                obs_cu_last = cyc;
            end
            if (out_done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
            end
            if (cyc == 10) obs_busy_mid = out_busy;
            if (cyc == 2001) begin
                obs_cnt_pulse   = int'(out_cand_cnt);
                exp_cnt_pulse   = (sent > NCAND) ? NCAND : sent;
                obs_cu_at_pulse = out_cu_ena;
            end
            in_start = pulse && (cyc == 50 || cyc == 2000 || cyc == RUNC - 1 || cyc == exp_done_cyc);
            send = 1'b0;
            if (cyc < 4000 && sent < n_early) send = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (late >= 0 && cyc == RUNC + late) send = 1'b1;
            in_sad_valid = send;
            if (send) begin
                in_sad = sads[sent];
                sent++;
            end else begin
                in_sad = SW'($urandom);
            end
            @(posedge in_clk); #1;
        end
        in_start     = 1'b0;
        in_sad_valid = 1'b0;
        obs_cnt      = int'(out_cand_cnt);
        obs_best     = out_best_sad;
        obs_mx       = int'(out_best_mv_x);
        obs_my       = int'(out_best_mv_y);
        obs_err      = out_err;
        obs_busy_end = out_busy;
        // Valids in IDLE must not disturb the held result.
        snap_best = out_best_sad; snap_cnt = out_cand_cnt; snap_err = out_err;
        snap_mx = out_best_mv_x;  snap_my = out_best_mv_y;
        for (int k = 0; k < 5; k++) begin
            in_sad_valid = 1'b1;
            in_sad       = '0;
            @(posedge in_clk); #1;
        end
        in_sad_valid = 1'b0;
        obs_idle_stable = (out_best_sad === snap_best) && (out_cand_cnt === snap_cnt) &&
                          (out_err === snap_err) && (out_best_mv_x === snap_mx) &&
                          (out_best_mv_y === snap_my) && (out_busy === 1'b0);
    endtask

    task automatic test_reset();
        in_rst = 1'b1; in_start = 1'b0; in_sad_valid = 1'b0; in_sad = '0;
        #12;
        checks++; if (out_cu_ena !== 1'b0)   begin errors++; $display("FAIL reset_cu_ena: got %b expected 0", out_cu_ena); end
        checks++; if (out_busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", out_busy); end
        checks++; if (out_done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", out_done); end
        checks++; if (out_err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b expected 0", out_err); end
        checks++; if (out_cand_cnt !== 9'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", out_cand_cnt); end
        checks++; if (out_best_sad !== '0)   begin errors++; $display("FAIL reset_best: got %0d expected 0", out_best_sad); end
        checks++; if (out_best_mv_x !== 4'd0 || out_best_mv_y !== 4'd0)
            begin errors++; $display("FAIL reset_mv: got %0d,%0d expected 0,0", out_best_mv_x, out_best_mv_y); end
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        @(posedge in_clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 260; i++) sads[i] = 16'd1000;
        sads[37] = 16'd5;
        do_search(256, 1'b0, 1'b0, -1);
        checks++; if (obs_cnt != 256)  begin errors++; $display("FAIL basic_cnt: got %0d expected 256", obs_cnt); end
        checks++; if (obs_best != 5)   begin errors++; $display("FAIL basic_best: got %0d expected 5", obs_best); end
        checks++; if (obs_mx != 5 || obs_my != 2)
            begin errors++; $display("FAIL basic_mv: got %0d,%0d expected 5,2", obs_mx, obs_my); end
        checks++; if (obs_err != 0)    begin errors++; $display("FAIL basic_err: got %0d expected 0", obs_err); end
        checks++; if (obs_done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", obs_done_cnt); end
        checks++; if (obs_done_cyc != RUNC) begin errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", obs_done_cyc, RUNC); end
        checks++; if (!obs_idle_stable) begin errors++; $display("FAIL basic_idle_hold: got unstable expected stable"); end
    endtask

    task automatic test_cu_window();
        for (int i = 0; i < 260; i++) sads[i] = SW'($urandom_range(0, 5000));
        do_search(256, 1'b1, 1'b1, -1);
        checks++; if (obs_cu_first != 0) begin errors++; $display("FAIL cu_first: got %0d expected 0", obs_cu_first); end
        checks++; if (obs_cu_cycles != RUNC) begin errors++; $display("FAIL cu_cycles: got %0d expected %0d", obs_cu_cycles, RUNC); end
        checks++; if (obs_cu_last != RUNC - 1) begin errors++; $display("FAIL cu_last: got %0d expected %0d", obs_cu_last, RUNC - 1); end
        checks++; if (obs_cnt_pulse != exp_cnt_pulse || !obs_cu_at_pulse)
            begin errors++; $display("FAIL start_in_run: got cnt %0d cu %0d expected cnt %0d cu 1", obs_cnt_pulse, obs_cu_at_pulse, exp_cnt_pulse); end
        checks++; if (!obs_busy_mid || obs_busy_end) begin errors++; $display("FAIL busy: got mid %0d end %0d expected 1 0", obs_busy_mid, obs_busy_end); end
        checks++; if (obs_done_cnt != 1 || obs_done_cyc != exp_done_cyc)
            begin errors++; $display("FAIL cu_done: got %0d pulses at %0d expected 1 at %0d", obs_done_cnt, obs_done_cyc, exp_done_cyc); end
        checks++; if (obs_best != exp_best || obs_mx != exp_idx % 16 || obs_my != exp_idx / 16)
            begin errors++; $display("FAIL cu_best: got %0d@%0d,%0d expected %0d@%0d", obs_best, obs_mx, obs_my, exp_best, exp_idx); end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 260; i++) sads[i] = 16'd1000;
        sads[10] = 16'd7; sads[200] = 16'd7;
        do_search(256, 1'b1, 1'b0, -1);
        checks++; if (obs_best != 7 || obs_mx != 10 || obs_my != 0)
            begin errors++; $display("FAIL tie: got %0d@%0d,%0d expected 7@10,0", obs_best, obs_mx, obs_my); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 260; i++) sads[i] = SW'($urandom_range(1, 3000));
        do_search(250, 1'b1, 1'b0, -1);
        checks++; if (obs_err != 1)   begin errors++; $display("FAIL timeout_err: got %0d expected 1", obs_err); end
        checks++; if (obs_cnt != 250) begin errors++; $display("FAIL timeout_cnt: got %0d expected 250", obs_cnt); end
        checks++; if (obs_done_cnt != 1 || obs_done_cyc != RUNC + DRNC)
            begin errors++; $display("FAIL timeout_done: got %0d pulses at %0d expected 1 at %0d", obs_done_cnt, obs_done_cyc, RUNC + DRNC); end
        checks++; if (obs_best != exp_best || obs_mx != exp_idx % 16 || obs_my != exp_idx / 16)
            begin errors++; $display("FAIL timeout_best: got %0d@%0d,%0d expected %0d@%0d", obs_best, obs_mx, obs_my, exp_best, exp_idx); end
    endtask

    // Last SAD arrives in DRAIN; late = 31 lands on the timeout edge itself.
    task automatic test_drain_finish(input int late);
        for (int i = 0; i < 260; i++) sads[i] = SW'($urandom_range(1, 3000));
        sads[255] = 16'd0;
        do_search(256, 1'b1, 1'b0, late);
        checks++; if (obs_err != 0 || obs_cnt != 256)
            begin errors++; $display("FAIL drain_late%0d_status: got err %0d cnt %0d expected 0 256", late, obs_err, obs_cnt); end
        checks++; if (obs_done_cnt != 1 || obs_done_cyc != exp_done_cyc)
            begin errors++; $display("FAIL drain_late%0d_done: got %0d pulses at %0d expected 1 at %0d", late, obs_done_cnt, obs_done_cyc, exp_done_cyc); end
        checks++; if (obs_best != 0 || obs_mx != 15 || obs_my != 15)
            begin errors++; $display("FAIL drain_late%0d_best: got %0d@%0d,%0d expected 0@15,15", late, obs_best, obs_mx, obs_my); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 256; i++) sads[i] = SW'($urandom_range(1, 4000));
        for (int i = 256; i < 260; i++) sads[i] = 16'd0;
        do_search(260, 1'b1, 1'b0, -1);
        checks++; if (obs_cnt != 256) begin errors++; $display("FAIL sat_cnt: got %0d expected 256", obs_cnt); end
        checks++; if (obs_best != exp_best || obs_mx != exp_idx % 16 || obs_my != exp_idx / 16)
            begin errors++; $display("FAIL sat_best: got %0d@%0d,%0d expected %0d@%0d", obs_best, obs_mx, obs_my, exp_best, exp_idx); end
        checks++; if (obs_err != 0 || obs_done_cnt != 1)
            begin errors++; $display("FAIL sat_done: got err %0d pulses %0d expected 0 1", obs_err, obs_done_cnt); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        int cu_seen;
        done_seen = 0; cu_seen = 0;
        @(posedge in_clk); #1;
        in_start = 1'b1;
        @(posedge in_clk); #1;
        in_start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            in_sad_valid = 1'b1;
            in_sad       = SW'($urandom_range(0, 999));
            @(posedge in_clk); #1;
        end
        in_sad_valid = 1'b0;
        in_rst = 1'b1;
        #1;
        checks++; if (out_cu_ena !== 1'b0 || out_busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_immediate: got cu %b busy %b expected 0 0", out_cu_ena, out_busy); end
        checks++; if (out_cand_cnt !== 9'd0 || out_best_sad !== '0 || out_err !== 1'b0 ||
                      out_best_mv_x !== 4'd0 || out_best_mv_y !== 4'd0 || out_done !== 1'b0)
            begin errors++; $display("FAIL rstmid_values: got cnt %0d best %0d err %b mv %0d,%0d done %b expected all 0",
                                     out_cand_cnt, out_best_sad, out_err, out_best_mv_x, out_best_mv_y, out_done); end
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        for (int cyc = 0; cyc < RUNC + DRNC + 20; cyc++) begin
            if (out_done) done_seen++;
            if (out_cu_ena) cu_seen++;
            @(posedge in_clk); #1;
        end
        checks++; if (done_seen != 0 || cu_seen != 0)
            begin errors++; $display("FAIL rstmid_aborted: got done %0d cu %0d expected 0 0", done_seen, cu_seen); end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 2; r++) begin
            n = int'($urandom_range(250, 260));
            for (int i = 0; i < 260; i++) sads[i] = SW'($urandom_range(0, 300));
            do_search(n, 1'b1, 1'b0, -1);
            checks++; if (obs_cnt != exp_cnt || obs_err != exp_err)
                begin errors++; $display("FAIL rand%0d_status: got cnt %0d err %0d expected %0d %0d", r, obs_cnt, obs_err, exp_cnt, exp_err); end
            checks++; if (obs_best != exp_best || obs_mx != exp_idx % 16 || obs_my != exp_idx / 16)
                begin errors++; $display("FAIL rand%0d_best: got %0d@%0d,%0d expected %0d@%0d", r, obs_best, obs_mx, obs_my, exp_best, exp_idx); end
            checks++; if (obs_done_cnt != 1 || obs_done_cyc != exp_done_cyc)
                begin errors++; $display("FAIL rand%0d_done: got %0d pulses at %0d expected 1 at %0d", r, obs_done_cnt, obs_done_cyc, exp_done_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cu_window();
        test_tie();
        test_timeout();
        test_drain_finish(5);
        test_drain_finish(31);
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/me_search_sequencer.md
ME_SEARCH_SEQUENCER -- requirements
Module: me_search_sequencer

Interface
REQ-001 SHALL have parameter SAD_WIDTH, default 16: bit width of one SAD value.
REQ-002 SHALL have parameter CAND_COUNT, default 256: SAD results per search (16x16 candidate grid).
REQ-003 SHALL have parameter RUN_CYCLES, default 4096: cycles the control unit is held enabled per search.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 32: maximum wait for outstanding SADs after RUN.
REQ-005 SHALL have port in_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port in_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_start  input  1  search request, sampled only in IDLE.
REQ-008 SHALL have port in_sad_valid  input  1  in_sad carries one candidate result this cycle.
REQ-009 SHALL have port in_sad  input  SAD_WIDTH  candidate SAD, in raster order (x fastest).
REQ-010 SHALL have port out_cu_ena  output  1  enable to the control unit (drives its in_cu_ena).
REQ-011 SHALL have port out_busy  output  1  high in RUN and DRAIN.
REQ-012 SHALL have port out_done  output  1  one-cycle pulse at search completion.
REQ-013 SHALL have port out_err  output  1  last search timed out in DRAIN; held until next start.
REQ-014 SHALL have port out_best_sad  output  SAD_WIDTH  minimum SAD of current/last search.
REQ-015 SHALL have port out_best_mv_x  output  4  x offset of best candidate (index bits [3:0]).
REQ-016 SHALL have port out_best_mv_y  output  4  y offset of best candidate (index bits [7:4]).
REQ-017 SHALL have port out_cand_cnt  output  $clog2(CAND_COUNT)+1  SADs accepted in current search.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-019 SHALL, in IDLE with in_start=1, enter RUN next edge and clear out_cand_cnt, out_err, out_best_mv_x/y to 0 and out_best_sad to all-ones.
REQ-020 SHALL drive out_cu_ena=1 for exactly RUN_CYCLES consecutive cycles, beginning the first cycle in RUN.
REQ-021 SHALL move RUN->DRAIN on the edge ending the RUN_CYCLES-th enabled cycle; out_cu_ena=0 from DRAIN onward.
REQ-022 SHALL accept in_sad_valid only in RUN or DRAIN and only while out_cand_cnt < CAND_COUNT; other valids ignored.
REQ-023 SHALL, per accepted SAD, increment out_cand_cnt by 1; candidate index = out_cand_cnt value before increment.
REQ-024 SHALL load best SAD/mv from the first accepted SAD unconditionally; thereafter only when in_sad < out_best_sad (strict; ties keep lower index).
REQ-025 SHALL move to DONE when out_cand_cnt reaches CAND_COUNT in DRAIN, or at RUN->DRAIN if count already equals CAND_COUNT.
REQ-026 SHALL move DRAIN->DONE with out_err=1 after DRAIN_CYCLES cycles in DRAIN without reaching CAND_COUNT.
REQ-027 SHALL assert out_done for exactly the one cycle in DONE, then return to IDLE; in_start in DONE ignored.
REQ-028 SHALL ignore in_start in RUN, DRAIN and DONE with no effect on counters.
REQ-029 SHALL hold out_best_sad, out_best_mv_x/y, out_cand_cnt, out_err stable in IDLE until next accepted start.
REQ-030 SHALL, when the final SAD and the DRAIN timeout coincide, treat the search as complete (out_err=0).

Reset
REQ-031 SHALL on in_rst=1, asynchronously, enter IDLE with out_cu_ena, out_busy, out_done, out_err, out_cand_cnt, out_best_mv_x/y = 0 and out_best_sad = 0.
REQ-032 SHALL, on reset mid-search, drop out_cu_ena in the same cycle and never emit out_done for the aborted search.

Verification
REQ-033 SHALL test: reset, in_start pulse, 256 SADs with value 1000 except index 37 = 5 -> out_done once, best_sad=5, mv_x=5, mv_y=2, cnt=256, err=0.
REQ-034 SHALL test: out_cu_ena high exactly 4096 cycles starting cycle after start edge; in_start pulses during RUN -> no restart, count unchanged.
REQ-035 SHALL test: indices 10 and 200 both SAD=7 (minimum) -> best mv_x=10, mv_y=0.
REQ-036 SHALL test: only 250 SADs delivered -> out_done 32 cycles after DRAIN entry, out_err=1, cnt=250.
REQ-037 SHALL test: in_rst asserted at RUN cycle 100 -> out_cu_ena/out_busy 0 immediately, no out_done, outputs at reset values.
REQ-038 SHALL test: 260 valids in a search -> cnt saturates 256, SADs 257-260 (value 0) do not change best.
